// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, imem handshake and IF/ID register
module fetch_stage #(
    parameter int                 PC_W     = 8,
    parameter int                 INSTR_W  = 16,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP      = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_write,
    input  logic               if_id_write,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               flush,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic [2:0]         if_id_rs,
    output logic [2:0]         if_id_rt
);

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t             state;
    logic [PC_W-1:0]    fetch_addr;
    logic [INSTR_W-1:0] hold_instr;
    logic [PC_W-1:0]    hold_addr;
    logic               hold_adv;
    logic               accept;
    logic [PC_W-1:0]    addr_inc;
    logic [PC_W-1:0]    hold_inc;

    assign accept    = imem_req && imem_ready;
    assign addr_inc  = fetch_addr + PC_W'(1);
    assign hold_inc  = hold_addr + PC_W'(1);
    assign imem_addr = fetch_addr;
    assign if_id_rs  = if_id_instr[11:9];
    assign if_id_rt  = if_id_instr[8:6];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            fetch_addr  <= RESET_PC;
            imem_req    <= 1'b0;
            if_id_instr <= NOP;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            hold_instr  <= NOP;
            hold_addr   <= '0;
            hold_adv    <= 1'b0;
        end else if (branch_taken) begin
            pc          <= branch_target;
            if_id_instr <= NOP;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            hold_adv    <= 1'b0;
            imem_req    <= 1'b1;
            // A request still in flight must complete at its old address first.
            if (state == HOLD || accept || (state == FETCH && !imem_req)) begin
                fetch_addr <= branch_target;
                state      <= FETCH;
            end else begin
                state <= DROP;
            end
        end else begin
            case (state)
                FETCH: begin
                    imem_req <= 1'b1;
                    if (flush) begin
                        if_id_instr <= NOP;
                        if_id_pc    <= '0;
                        if_id_valid <= 1'b0;
                    end
                    if (accept) begin
                        if (if_id_write && !flush) begin
                            if_id_instr <= imem_rdata;
                            if_id_pc    <= fetch_addr;
                            if_id_valid <= 1'b1;
                        end else begin
                            hold_instr <= imem_rdata;
                            hold_addr  <= fetch_addr;
                            hold_adv   <= pc_write;
                            state      <= HOLD;
                            imem_req   <= 1'b0;
                        end
                        if (pc_write) begin
                            pc         <= addr_inc;
                            fetch_addr <= addr_inc;
                        end
                    end
                end
                HOLD: begin
                    if (flush) begin
                        if_id_instr <= NOP;
                        if_id_pc    <= '0;
                        if_id_valid <= 1'b0;
                    end else if (if_id_write) begin
                        if_id_instr <= hold_instr;
                        if_id_pc    <= hold_addr;
                        if_id_valid <= 1'b1;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                        // pc already moved past the buffered word if it advanced at capture.
                        if (pc_write && !hold_adv) begin
                            pc         <= hold_inc;
                            fetch_addr <= hold_inc;
                        end else begin
                            fetch_addr <= pc;
                        end
                    end
                end
                DROP: begin
                    imem_req <= 1'b1;
                    if (flush) begin
                        if_id_instr <= NOP;
                        if_id_pc    <= '0;
                        if_id_valid <= 1'b0;
                    end
                    if (accept) begin
                        fetch_addr <= pc;
                        state      <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        if_id_write;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        flush;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [7:0]  pc;
    logic [15:0] if_id_instr;
    logic [7:0]  if_id_pc;
    logic        if_id_valid;
    logic [2:0]  if_id_rs;
    logic [2:0]  if_id_rt;
    logic [15:0] mem_mix;

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
        .branch_taken(branch_taken), .branch_target(branch_target), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .pc(pc), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .if_id_rs(if_id_rs),
        .if_id_rt(if_id_rt)
    );

    always #5 clk = ~clk;

    // Memory model: word at address a is 16'h1000 + a, optionally scrambled.
    assign imem_rdata = (16'h1000 + {8'h00, imem_addr}) ^ mem_mix;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_write = 1'b1; if_id_write = 1'b1; branch_taken = 1'b0;
        branch_target = 8'h00; flush = 1'b0; imem_ready = 1'b1; mem_mix = 16'h0000;
        #2;
        chk("rst_pc",    16'(pc), 16'h0000);
        chk("rst_req",   16'(imem_req), 16'h0000);
        chk("rst_valid", 16'(if_id_valid), 16'h0000);
        chk("rst_instr", if_id_instr, 16'h0000);
        #10 rst = 1'b0;

        step;
        chk("first_req",   16'(imem_req), 16'h0001);
        chk("first_addr",  16'(imem_addr), 16'h0000);
        chk("first_valid", 16'(if_id_valid), 16'h0000);
        step;
        chk("seq0_pc",    16'(if_id_pc), 16'h0000);
        chk("seq0_valid", 16'(if_id_valid), 16'h0001);
        chk("seq0_instr", if_id_instr, 16'h1000);
        chk("seq0_rs",    16'(if_id_rs), 16'h0000);
        chk("seq0_npc",   16'(pc), 16'h0001);
        step;
        chk("seq1_pc", 16'(if_id_pc), 16'h0001);
        step;
        chk("seq2_pc", 16'(if_id_pc), 16'h0002);
        chk("seq2_npc", 16'(pc), 16'h0003);

        pc_write = 1'b0; if_id_write = 1'b0;
        step;
        chk("stall_ifpc", 16'(if_id_pc), 16'h0002);
        chk("stall_req",  16'(imem_req), 16'h0000);
        chk("stall_npc",  16'(pc), 16'h0003);
        pc_write = 1'b1; if_id_write = 1'b1;
        step;
        chk("release_ifpc",  16'(if_id_pc), 16'h0003);
        chk("release_instr", if_id_instr, 16'h1003);
        chk("release_npc",   16'(pc), 16'h0004);
        chk("release_addr",  16'(imem_addr), 16'h0004);
        step;
        chk("seq4_pc", 16'(if_id_pc), 16'h0004);
        chk("seq4_addr", 16'(imem_addr), 16'h0005);

        imem_ready = 1'b0;
        step;
        chk("wait1_addr", 16'(imem_addr), 16'h0005);
        branch_taken = 1'b1; branch_target = 8'h40;
        step;
        branch_taken = 1'b0;
        chk("drop_addr",  16'(imem_addr), 16'h0005);
        chk("drop_npc",   16'(pc), 16'h0040);
        chk("drop_valid", 16'(if_id_valid), 16'h0000);
        chk("drop_req",   16'(imem_req), 16'h0001);
        step;
        chk("wait3_addr", 16'(imem_addr), 16'h0005);
        imem_ready = 1'b1;
        step;
        chk("discard_addr",  16'(imem_addr), 16'h0040);
        chk("discard_valid", 16'(if_id_valid), 16'h0000);
        chk("discard_instr", if_id_instr, 16'h0000);
        step;
        chk("tgt_ifpc",  16'(if_id_pc), 16'h0040);
        chk("tgt_instr", if_id_instr, 16'h1040);
        chk("tgt_rt",    16'(if_id_rt), 16'h0001);
        chk("tgt_npc",   16'(pc), 16'h0041);

        if_id_write = 1'b0; branch_taken = 1'b1; branch_target = 8'hFF;
        step;
        branch_taken = 1'b0; if_id_write = 1'b1;
        chk("brrdy_valid", 16'(if_id_valid), 16'h0000);
        chk("brrdy_instr", if_id_instr, 16'h0000);
        chk("brrdy_addr",  16'(imem_addr), 16'h00FF);
        step;
        chk("wrap_ifpc", 16'(if_id_pc), 16'h00FF);
        chk("wrap_rt",   16'(if_id_rt), 16'h0003);
        chk("wrap_npc",  16'(pc), 16'h0000);
        chk("wrap_addr", 16'(imem_addr), 16'h0000);

        flush = 1'b1; mem_mix = 16'h0E00;
        step;
        flush = 1'b0;
        chk("flush_valid", 16'(if_id_valid), 16'h0000);
        chk("flush_req",   16'(imem_req), 16'h0000);
        chk("flush_npc",   16'(pc), 16'h0001);
        step;
        mem_mix = 16'h0000;
        chk("unhold_ifpc",  16'(if_id_pc), 16'h0000);
        chk("unhold_rs",    16'(if_id_rs), 16'h0007);
        chk("unhold_valid", 16'(if_id_valid), 16'h0001);
        chk("unhold_npc",   16'(pc), 16'h0001);
        chk("unhold_addr",  16'(imem_addr), 16'h0001);

        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 8'h80;
        step;
        branch_taken = 1'b0;
        chk("drop2_addr", 16'(imem_addr), 16'h0001);
        chk("drop2_npc",  16'(pc), 16'h0080);
        #3 rst = 1'b1;
        #1;
        chk("arst_pc",   16'(pc), 16'h0000);
        chk("arst_req",  16'(imem_req), 16'h0000);
        chk("arst_addr", 16'(imem_addr), 16'h0000);
        #2 rst = 1'b0; imem_ready = 1'b1;
        step;
        chk("post_req",  16'(imem_req), 16'h0001);
        chk("post_addr", 16'(imem_addr), 16'h0000);
        step;
        chk("post_ifpc",  16'(if_id_pc), 16'h0000);
        chk("post_valid", 16'(if_id_valid), 16'h0001);
        chk("post_npc",   16'(pc), 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
